// File: rtl/bitplane_encoder_if.sv
// rtl/bitplane_encoder_if.sv - input/output stream bundle for the bit-plane encoder
interface bitplane_encoder_if #(
   parameter int IO_DATA_WIDTH = 8,
   parameter int MEM_BW        = 128
);
   logic                     in_valid;
   logic                     in_ready;
   logic [IO_DATA_WIDTH-1:0] in_data [0:15];
   logic                     out_valid;
   logic                     out_ready;
   logic [15:0]              out_mask;
   logic [MEM_BW-1:0]        out_data;
   logic [4:0]               out_planes;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_mask, out_data, out_planes
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_mask, out_data, out_planes
   );
endinterface

// File: rtl/bitplane_encoder.sv
// rtl/bitplane_encoder.sv - two-stage bit-plane encoder: S1 holds block and mask, S2 holds packed planes
module bitplane_encoder #(
   parameter int IO_DATA_WIDTH = 8,
   parameter int MEM_BW        = 128
) (
   input logic               clk,
   input logic               arst_n_in,
   bitplane_encoder_if.slave bus
);
   logic [15:0][7:0]         in_pl;
   logic [15:0][7:0]         s1_pl;
   logic [15:0]              in_mask;
   logic                     s1_valid;
   logic [IO_DATA_WIDTH-1:0] s1_data [0:15];
   logic [15:0]              s1_mask;
   logic [MEM_BW-1:0]        pk_data;
   logic [4:0]               pk_cnt;
   logic                     o_valid;
   logic [15:0]              o_mask;
   logic [MEM_BW-1:0]        o_data;
   logic [4:0]               o_planes;
   logic                     s2_load;
   logic                     in_fire;

   assign s2_load      = s1_valid && (!o_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_load;
   assign in_fire      = bus.in_valid && bus.in_ready;

   assign bus.out_valid  = o_valid;
   assign bus.out_mask   = o_mask;
   assign bus.out_data   = o_data;
   assign bus.out_planes = o_planes;

   // Plane index p runs in packing order: p=0..7 is group 0 bits 7..0, p=8..15 is group 1.
   always_comb begin
      in_pl   = '0;
      s1_pl   = '0;
      in_mask = '0;
      for (int p = 0; p < 16; p++) begin
         for (int i = 0; i < 8; i++) begin
            in_pl[p][7-i] = bus.in_data[8*(p/8)+i][7-(p%8)];
            s1_pl[p][7-i] = s1_data[8*(p/8)+i][7-(p%8)];
         end
         in_mask[15-p] = |in_pl[p];
      end
   end

   always_comb begin
      pk_data = '0;
      pk_cnt  = '0;
      for (int p = 0; p < 16; p++) begin
         if (s1_mask[15-p]) begin
            pk_data = pk_data | ({s1_pl[p], {(MEM_BW-8){1'b0}}} >> {pk_cnt, 3'b000});
            pk_cnt  = pk_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         s1_valid <= 1'b0;
         s1_data  <= '{default: '0};
         s1_mask  <= '0;
         o_valid  <= 1'b0;
         o_mask   <= '0;
         o_data   <= '0;
         o_planes <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= bus.in_data;
            s1_mask  <= in_mask;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
         if (s2_load) begin
            o_valid  <= 1'b1;
            o_mask   <= s1_mask;
            o_data   <= pk_data;
            o_planes <= pk_cnt;
         end else if (bus.out_ready) begin
            o_valid  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bitplane_encoder.sv
// tb/tb_bitplane_encoder.sv - randomized scoreboard bench for bitplane_encoder
module tb_bitplane_encoder;
   typedef logic [7:0] blk_t [0:15];
   typedef struct {
      logic [15:0]  mask;
      logic [127:0] data;
      logic [4:0]   planes;
      blk_t         d;
   } exp_t;

   logic clk = 1'b0;
   logic arst_n_in;
   always #5 clk = ~clk;

   bitplane_encoder_if #(.IO_DATA_WIDTH(8), .MEM_BW(128)) bif ();
   bitplane_encoder #(.IO_DATA_WIDTH(8), .MEM_BW(128)) dut (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .bus       (bif)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   ready_mode = 1;
   exp_t q[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input blk_t d);
      exp_t       e;
      int         n;
      logic [7:0] pb;
      n = 0;
      e.mask = '0;
      e.data = '0;
      e.d    = d;
      for (int g = 0; g < 2; g++) begin
         for (int b = 7; b >= 0; b--) begin
            pb = '0;
            for (int i = 0; i < 8; i++) if (d[8*g+i][b]) pb[7-i] = 1'b1;
            if (pb != 0) begin
               e.mask[b+8*(1-g)] = 1'b1;
               e.data[127-8*n -: 8] = pb;
               n++;
            end
         end
      end
      e.planes = 5'(n);
      return e;
   endfunction

   function automatic blk_t decode(input logic [15:0] m, input logic [127:0] data);
      blk_t       d;
      int         n;
      logic [7:0] pb;
      n = 0;
      for (int i = 0; i < 16; i++) d[i] = 8'h00;
      for (int g = 0; g < 2; g++) begin
         for (int b = 7; b >= 0; b--) begin
            if (m[b+8*(1-g)]) begin
               pb = data[127-8*n -: 8];
               n++;
               for (int i = 0; i < 8; i++) d[8*g+i][b] = pb[7-i];
            end
         end
      end
      return d;
   endfunction

   function automatic logic [127:0] flat(input blk_t d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = d[i];
      return r;
   endfunction

   function automatic blk_t rand_blk();
      blk_t d;
      int   dens;
      dens = $urandom_range(0, 4);
      for (int i = 0; i < 16; i++) begin
         if (dens == 0)
            d[i] = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         else
            d[i] = ($urandom_range(0, 3) < dens) ? 8'($urandom) : 8'h00;
      end
      return d;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the block.
   task automatic send(input blk_t d, input bit use_c, input logic [15:0] cm,
                       input logic [127:0] cd, input logic [4:0] cp);
      exp_t e;
      bit   done;
      done = 1'b0;
      e = model(d);
      if (use_c) begin
         e.mask   = cm;
         e.data   = cd;
         e.planes = cp;
      end
      bif.in_valid = 1'b1;
      bif.in_data  = d;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (bif.in_ready) begin
            q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL in_accept_timeout: got in_ready=0 required 1");
      end
      bif.in_valid = 1'b0;
      bif.in_data  = rand_blk();
   endtask

   task automatic send_c(input blk_t d, input logic [15:0] cm, input logic [127:0] cd,
                         input logic [4:0] cp);
      send(d, 1'b1, cm, cd, cp);
   endtask

   task automatic drain();
      for (int k = 0; k < 600 && q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending required 0", q.size());
      end
   endtask

   task automatic random_run(input int nblk);
      for (int n = 0; n < nblk; n++) begin
         send(rand_blk(), 1'b0, '0, '0, '0);
         repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 128'(bif.out_valid), 128'd0);
      chk({tag, "_in_ready"}, 128'(bif.in_ready), 128'd1);
      chk({tag, "_out_mask"}, 128'(bif.out_mask), 128'd0);
      chk({tag, "_out_data"}, bif.out_data, 128'd0);
      chk({tag, "_out_planes"}, 128'(bif.out_planes), 128'd0);
   endtask

   initial begin
      bif.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bif.out_ready = ($urandom_range(0, 3) != 0);
            1:       bif.out_ready = 1'b1;
            default: bif.out_ready = 1'b0;
         endcase
      end
   end

   // Scoreboard monitor: the head entry must be on the outputs every cycle out_valid is high.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (arst_n_in && bif.out_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stale_output: got mask %0h with nothing pending", bif.out_mask);
            end else begin
               e = q[0];
               chk("out_mask", 128'(bif.out_mask), 128'(e.mask));
               chk("out_data", bif.out_data, e.data);
               chk("out_planes", 128'(bif.out_planes), 128'(e.planes));
               chk("roundtrip", flat(decode(bif.out_mask, bif.out_data)), flat(e.d));
               if (bif.out_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      blk_t d;
      arst_n_in    = 1'b0;
      bif.in_valid = 1'b0;
      bif.in_data  = rand_blk();
      ready_mode   = 1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      arst_n_in = 1'b1;

      for (int i = 0; i < 16; i++) d[i] = 8'h00;
      send_c(d, 16'h0000, 128'h0, 5'd0);
      d[0] = 8'h80;
      send_c(d, 16'h8000, {8'h80, 120'h0}, 5'd1);
      d[8] = 8'h01;
      send_c(d, 16'h8001, {8'h80, 8'h80, 112'h0}, 5'd2);
      for (int i = 0; i < 16; i++) d[i] = 8'hFF;
      send_c(d, 16'hFFFF, {128{1'b1}}, 5'd16);
      for (int i = 0; i < 16; i++) d[i] = 8'h00;
      d[15] = 8'h01;
      send_c(d, 16'h0001, {8'h01, 120'h0}, 5'd1);
      drain();

      ready_mode = 0;
      random_run(200);
      ready_mode = 1;
      drain();

      ready_mode = 2;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      send(rand_blk(), 1'b0, '0, '0, '0);
      send(rand_blk(), 1'b0, '0, '0, '0);
      fork
         send(rand_blk(), 1'b0, '0, '0, '0);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("full_in_ready", 128'(bif.in_ready), 128'd0);
               chk("stall_out_valid", 128'(bif.out_valid), 128'd1);
            end
            ready_mode = 1;
         end
      join
      send(rand_blk(), 1'b0, '0, '0, '0);
      drain();

      ready_mode = 2;
      send(rand_blk(), 1'b0, '0, '0, '0);
      send(rand_blk(), 1'b0, '0, '0, '0);
      arst_n_in = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      arst_n_in  = 1'b1;
      ready_mode = 0;
      random_run(300);
      ready_mode = 1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
